// File: rtl/tile_map_arbiter.sv
// Single-port tile RAM arbiter for the snake grid: VGA reads > map clear > queued game writes.
// Optional macro TILE_BYPASS_EN forwards pending queued writes to reads that hit them.
module tile_map_arbiter #(
  parameter int GRID_W     = 64,
  parameter int GRID_H     = 48,
  parameter int DATA_W     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_req,
  input  logic [5:0]                    rd_x,
  input  logic [5:0]                    rd_y,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [5:0]                    wr_x,
  input  logic [5:0]                    wr_y,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          clr_req,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          range_err,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [11:0]                   ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata
);
  localparam int AW    = 12;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;
  localparam int CELLS = GRID_W * GRID_H;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  typedef struct packed {
    logic              bad;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [AW-1:0] cell_addr(input logic [5:0] x, input logic [5:0] y);
    return AW'(y) * AW'(GRID_W) + AW'(x);
  endfunction

  function automatic logic in_grid(input logic [5:0] x, input logic [5:0] y);
    return (int'(x) < GRID_W) && (int'(y) < GRID_H);
  endfunction

  state_t          state, state_nx;
  logic [AW-1:0]   clr_cnt;
  entry_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   head_ptr, tail_ptr;
  logic [LW-1:0]   level;
  entry_t          head;
  logic [AW-1:0]   rd_addr;
  logic            rd_hit, clr_go, clr_wr, push, pop;
  logic            rd_valid_q, rd_in_q;

  // Handshake: a write transfers on any rising clk edge where wr_valid && wr_ready;
  // wr_ready looks only at the registered level, so a same-cycle pop never frees a slot.
  assign rd_addr    = cell_addr(rd_x, rd_y);
  assign rd_hit     = !rst && rd_req && in_grid(rd_x, rd_y);
  assign clr_go     = !rst && clr_req && (state == S_IDLE);
  assign clr_wr     = !rst && (state == S_CLEAR) && !rd_hit;
  assign head       = fifo_mem[head_ptr];
  assign wr_ready   = !rst && (int'(level) < FIFO_DEPTH);
  assign push       = wr_valid && wr_ready && !clr_go;
  assign pop        = !rst && (level != '0) && !rd_hit && (state == S_IDLE) && !clr_go;
  assign fifo_level = level;
  assign rd_valid   = rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (clr_go) state_nx = S_CLEAR;
      S_CLEAR: if (clr_wr && (clr_cnt == AW'(CELLS - 1))) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_CLEAR);
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (rd_hit) begin
      ram_en   = 1'b1;
      ram_addr = rd_addr;
    end else if (clr_wr) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = clr_cnt;
    end else if (pop && !head.bad) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = head.addr;
      ram_wdata = head.data;
    end
  end

  // A read stalls the clear counter; it simply retries the same address next cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_go) clr_cnt <= '0;
    else if (clr_wr)   clr_cnt <= clr_cnt + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_go) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      level    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail_ptr] <= {!in_grid(wr_x, wr_y), cell_addr(wr_x, wr_y), wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst)                  range_err <= 1'b0;
    else if (pop && head.bad) range_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_in_q    <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      rd_in_q    <= rd_hit;
    end
  end

`ifdef TILE_BYPASS_EN
  logic              byp_hit, byp_hit_q, byp_zero_q;
  logic [DATA_W-1:0] byp_data, byp_data_q;

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (rd_hit && (LW'(i) < level) && !fifo_mem[head_ptr + PW'(i)].bad &&
          (fifo_mem[head_ptr + PW'(i)].addr == rd_addr)) begin
        byp_hit  = 1'b1;
        byp_data = fifo_mem[head_ptr + PW'(i)].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
      byp_zero_q <= 1'b0;
    end else begin
      byp_hit_q  <= byp_hit;
      byp_data_q <= byp_data;
      byp_zero_q <= (state == S_CLEAR);
    end
  end

  assign rd_data = !rd_valid_q            ? '0 :
                   byp_hit_q              ? byp_data_q :
                   (byp_zero_q || !rd_in_q) ? '0 : ram_rdata;
`else
  assign rd_data = (rd_valid_q && rd_in_q) ? ram_rdata : '0;
`endif

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Directed bench for tile_map_arbiter: behavioural RAM, expected-queue scoreboard
// for read results and RAM writes, plus direct checks of flags and port timing.
module tb_tile_map_arbiter;
  logic        clk, rst;
  logic        rd_req, rd_valid;
  logic [5:0]  rd_x, rd_y, wr_x, wr_y;
  logic [1:0]  rd_data, wr_data, ram_wdata, ram_rdata;
  logic        wr_valid, wr_ready, clr_req, busy, range_err, ram_en, ram_we;
  logic [3:0]  fifo_level;
  logic [11:0] ram_addr;

  logic [1:0]  mem [0:4095];
  logic [13:0] exp_wr_q[$];
  logic [1:0]  exp_rd_q[$];
  logic [13:0] e_wr;
  logic [1:0]  e_rd;
  int          total, bad;
  int          busy_cnt, n, wcnt;

  tile_map_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .fifo_level(fifo_level), .range_err(range_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // read-first single-port RAM
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks: called at posedge+1, leave the bench at the next posedge+1
  task automatic set_read(input int x, input int y, input int exp);
    rd_req = 1'b1;
    rd_x   = 6'(x);
    rd_y   = 6'(y);
    exp_rd_q.push_back(2'(exp));
  endtask

  task automatic set_write(input int x, input int y, input int d, input bit commit);
    wr_valid = 1'b1;
    wr_x     = 6'(x);
    wr_y     = 6'(y);
    wr_data  = 2'(d);
    if (commit) exp_wr_q.push_back({12'(y * 64 + x), 2'(d)});
  endtask

  task automatic do_read(input int x, input int y, input int exp);
    set_read(x, y, exp);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic do_write(input int x, input int y, input int d);
    set_write(x, y, d, 1'b1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((fifo_level != 4'd0 || busy) && k < 5000) begin
      tick();
      k++;
    end
    check("drain_in_time", int'(k < 5000), 1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) begin
          check("rd_unexpected", int'(rd_data) + 100, 0);
        end else begin
          e_rd = exp_rd_q.pop_front();
          check("rd_data", int'(rd_data), int'(e_rd));
        end
      end
      if (ram_en && ram_we) begin
        if (exp_wr_q.size() == 0) begin
          check("ram_wr_unexpected", int'({ram_addr, ram_wdata}) + 100000, 0);
        end else begin
          e_wr = exp_wr_q.pop_front();
          check("ram_wr_addr_data", int'({ram_addr, ram_wdata}), int'(e_wr));
        end
      end
      if (rd_req && rd_x < 6'd64 && rd_y < 6'd48) begin
        check("rd_port_en", int'(ram_en), 1);
        check("rd_port_we", int'(ram_we), 0);
        check("rd_port_addr", int'(ram_addr), int'(rd_y) * 64 + int'(rd_x));
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; rd_req = 1'b0; rd_x = '0; rd_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; clr_req = 1'b0;
    repeat (3) tick();
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_range_err", int'(range_err), 0);
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_ram_en", int'(ram_en), 0);
    check("rst_ram_we", int'(ram_we), 0);
    rst = 1'b0;
    tick();
    check("wr_ready_after_rst", int'(wr_ready), 1);

    // preload (5,7)=3 and (10,2)=2 through the queue
    do_write(5, 7, 3);
    do_write(10, 2, 2);
    wait_drain();

    // basic read: address in same cycle, data next cycle
    set_read(5, 7, 3);
    #1;
    check("rd57_addr", int'(ram_addr), 453);
    check("rd57_en", int'(ram_en), 1);
    tick();
    rd_req = 1'b0;
    check("rd57_valid", int'(rd_valid), 1);
    check("rd57_data", int'(rd_data), 3);

    // fill the queue under continuous reads, then watch it drain in order
    for (int i = 0; i < 8; i++) begin
      set_read(5, 7, 3);
      set_write(i, 20, (i + 1) % 4, 1'b1);
      tick();
    end
    set_read(5, 7, 3);
    set_write(9, 20, 1, 1'b0);
    #1;
    check("full_level", int'(fifo_level), 8);
    check("full_wr_ready", int'(wr_ready), 0);
    tick();
    rd_req = 1'b0;
    wr_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      check("drain_we", int'(ram_we), 1);
      tick();
    end
    check("drained_level", int'(fifo_level), 0);

    // writes held off by reads commit within 3 cycles of the reads ending
    for (int i = 0; i < 5; i++) begin
      set_read(5, 7, 3);
      if (i < 3) set_write(30 + i, 5, 2, 1'b1);
      else wr_valid = 1'b0;
      tick();
    end
    rd_req = 1'b0;
    wr_valid = 1'b0;
    wcnt = 0;
    for (int j = 0; j < 3; j++) begin
      #1;
      if (ram_we) wcnt++;
      tick();
    end
    check("late_commit_cnt", wcnt, 3);
    check("late_commit_level", int'(fifo_level), 0);

    // read and write of the same cell in one cycle: read sees old value
    set_read(10, 2, 2);
    set_write(10, 2, 1, 1'b1);
    tick();
    wr_valid = 1'b0;
`ifdef TILE_BYPASS_EN
    set_read(10, 2, 1);
`else
    set_read(10, 2, 2);
`endif
    tick();
    rd_req = 1'b0;
    wait_drain();
    do_read(10, 2, 1);

    // clear with entries queued; a same-cycle push is discarded
    for (int i = 0; i < 4; i++) begin
      set_read(5, 7, 3);
      set_write(40 + i, 10, 3, 1'b0);
      tick();
    end
    set_read(5, 7, 3);
    clr_req = 1'b1;
    set_write(50, 10, 3, 1'b0);
    for (int i = 0; i < 3072; i++) exp_wr_q.push_back({12'(i), 2'b00});
    tick();
    clr_req = 1'b0;
    rd_req = 1'b0;
    set_write(3, 3, 2, 1'b1);
    #1;
    check("clr_level_flushed", int'(fifo_level), 0);
    check("clr_busy", int'(busy), 1);
    busy_cnt = 1;
    tick();
    wr_valid = 1'b0;
    clr_req = 1'b1;
    n = 0;
    while (busy && n < 4000) begin
      if (n == 1) clr_req = 1'b0;
      busy_cnt++;
      n++;
      tick();
    end
    clr_req = 1'b0;
    check("clr_cycles", busy_cnt, 3072);
    check("clr_level_kept", int'(fifo_level), 1);
    wait_drain();
    do_read(3, 3, 2);
    do_read(40, 30, 0);
    do_read(5, 7, 0);
    do_read(10, 2, 0);

    // out-of-range write and read
    set_write(5, 50, 1, 1'b0);
    tick();
    wr_valid = 1'b0;
    #1;
    check("oor_wr_no_ram", int'(ram_en), 0);
    check("oor_wr_level", int'(fifo_level), 1);
    tick();
    check("range_err_set", int'(range_err), 1);
    check("oor_level_empty", int'(fifo_level), 0);
    set_read(0, 48, 0);
    #1;
    check("oor_rd_no_ram", int'(ram_en), 0);
    tick();
    rd_req = 1'b0;
    check("oor_rd_valid", int'(rd_valid), 1);
    repeat (3) tick();
    check("range_err_sticky", int'(range_err), 1);
    check("exp_rd_empty", exp_rd_q.size(), 0);
    check("exp_wr_empty", exp_wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
